fp_addsub_scheduler: RTL and testbench

//  Shares one multi-cycle FP add/sub datapath between two requesters.

---
 rtl/fp_addsub_scheduler_if.sv | 55 +++++
 rtl/fp_addsub_scheduler.sv | 148 ++++++++++++++
 tb/tb_fp_addsub_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/fp_addsub_scheduler_if.sv
// Bus bundle between the requesters, the shared FP add/sub unit, the
// response consumer and the scheduler. The scheduler owns the master
// modport; the surrounding environment (requesters, FPU, consumer) uses
// the slave modport.
interface fp_addsub_scheduler_if #(
    parameter int DATA_W = 32
);
    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic              req0_op;
    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic              req1_op;
    // Shared FP add/sub datapath
    logic              fpu_start;
    logic [DATA_W-1:0] fpu_a;
    logic [DATA_W-1:0] fpu_b;
    logic              fpu_opSel;
    logic              fpu_done;
    logic [DATA_W-1:0] fpu_result;
    // Response channel
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output fpu_start, fpu_a, fpu_b, fpu_opSel,
        input  fpu_done, fpu_result,
        output rsp_valid, rsp_id, rsp_data, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  fpu_start, fpu_a, fpu_b, fpu_opSel,
        output fpu_done, fpu_result,
        input  rsp_valid, rsp_id, rsp_data, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/fp_addsub_scheduler.sv
// Round-robin scheduler sharing one multi-cycle FP add/sub unit between two
// requesters. Latches the winner's operands, pulses start, waits for done
// (bounded by TIMEOUT cycles) and returns the result tagged with the owner.
// A timed-out operation returns a quiet NaN with the error flag set.
module fp_addsub_scheduler #(
    parameter  int DATA_W  = 32,
    parameter  int TIMEOUT = 16,
    localparam int TIMER_W = $clog2(TIMEOUT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    fp_addsub_scheduler_if.master bus,
    output logic [3:0]            leds
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [DATA_W-1:0]  QNAN      = DATA_W'(32'h7FC0_0000);
    localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(TIMEOUT - 1);

    localparam logic [3:0] LED_IDLE  = 4'b0001;
    localparam logic [3:0] LED_ISSUE = 4'b0010;
    localparam logic [3:0] LED_WAIT  = 4'b0100;
    localparam logic [3:0] LED_RESP  = 4'b1000;

    state_t              r_state;
    logic                r_rr_ptr;
    logic [TIMER_W-1:0]  r_timer;
    logic                r_id;
    logic                r_fpu_start;
    logic [DATA_W-1:0]   r_fpu_a;
    logic [DATA_W-1:0]   r_fpu_b;
    logic                r_fpu_op;
    logic                r_rsp_valid;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic [3:0]          r_leds;

    logic                w_grant_valid;
    logic                w_grant_id;
    logic [DATA_W-1:0]   w_sel_a;
    logic [DATA_W-1:0]   w_sel_b;
    logic                w_sel_op;

    // Pick the winner while idle: a lone requester wins, a tie goes to rr_ptr.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        w_grant_valid = 1'b0;
        w_grant_id    = 1'b0;
        if (r_state == S_IDLE) begin
            w_grant_valid = bus.req0_valid | bus.req1_valid;
            w_grant_id    = (bus.req0_valid & bus.req1_valid) ? r_rr_ptr : bus.req1_valid;
        end
        w_sel_a  = w_grant_id ? bus.req1_a  : bus.req0_a;
        w_sel_b  = w_grant_id ? bus.req1_b  : bus.req0_b;
        w_sel_op = w_grant_id ? bus.req1_op : bus.req0_op;
    end

    // Scheduler FSM with all datapath-facing and response outputs registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignment so every
            // flop samples pre-edge values regardless of statement order.
            r_state     <= S_IDLE;
            r_rr_ptr    <= 1'b0;
            r_timer     <= '0;
            r_id        <= 1'b0;
            r_fpu_start <= 1'b0;
            r_fpu_a     <= '0;
            r_fpu_b     <= '0;
            r_fpu_op    <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_leds      <= LED_IDLE;
        end else begin
            r_fpu_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_valid) begin
                        r_fpu_a     <= w_sel_a;
                        r_fpu_b     <= w_sel_b;
                        r_fpu_op    <= w_sel_op;
                        r_id        <= w_grant_id;
                        r_rr_ptr    <= ~w_grant_id;
                        r_fpu_start <= 1'b1;
                        r_state     <= S_ISSUE;
                        r_leds      <= LED_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Start is high for this cycle only; done is not looked at here.
                    r_timer <= '0;
                    r_state <= S_WAIT;
                    r_leds  <= LED_WAIT;
                end
                S_WAIT: begin
                    if (bus.fpu_done) begin
                        // A done on the timeout cycle still counts as success.
                        r_rsp_data  <= bus.fpu_result;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                        r_leds      <= LED_RESP;
                    end else if (r_timer == TIMER_MAX) begin
                        r_rsp_data  <= QNAN;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                        r_leds      <= LED_RESP;
                    end else begin
                        r_timer <= r_timer + TIMER_W'(1);
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= S_IDLE;
                        r_leds      <= LED_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_leds  <= LED_IDLE;
                end
            endcase
        end
    end

    assign bus.req0_ready = w_grant_valid & ~w_grant_id;
    assign bus.req1_ready = w_grant_valid &  w_grant_id;
    assign bus.fpu_start  = r_fpu_start;
    assign bus.fpu_a      = r_fpu_a;
    assign bus.fpu_b      = r_fpu_b;
    assign bus.fpu_opSel  = r_fpu_op;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.rsp_err    = r_rsp_err;
    assign leds           = r_leds;

endmodule

// File: tb/tb_fp_addsub_scheduler.sv
// Directed testbench for fp_addsub_scheduler. Inputs are driven and outputs
// sampled on the falling clock edge; the FP unit is played by hand.
module tb_fp_addsub_scheduler;

    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic       clk;
    logic       reset;
    logic [3:0] leds;

    int n_checks = 0;
    int n_errors = 0;

    fp_addsub_scheduler_if #(.DATA_W(DATA_W)) bus ();

    fp_addsub_scheduler #(
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .leds  (leds)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if it does not match.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Advance until the start pulse is seen, bounded to a few cycles.
    task automatic wait_for_start(input string tag);
        int n = 0;
        while (bus.fpu_start !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        check(tag, 32'(bus.fpu_start), 32'd1);
    endtask

    // Called in the ISSUE cycle: play the FP unit returning res on the
    // delay-th WAIT cycle; returns in the first RESP cycle.
    task automatic serve(input int delay, input logic [31:0] res);
        step();
        check("start_pulse", 32'(bus.fpu_start), 32'd0);
        for (int i = 1; i < delay; i++) step();
        bus.fpu_done   = 1'b1;
        bus.fpu_result = res;
        step();
        bus.fpu_done   = 1'b0;
        bus.fpu_result = '0;
    endtask

    logic [31:0] op_a [2];
    logic [31:0] op_b [2];
    logic        exp_id;
    int          wc;

    initial begin
        reset          = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = 1'b0;
        bus.fpu_done   = 1'b0; bus.fpu_result = '0;
        bus.rsp_ready  = 1'b1;
        step(); step();

        // Reset state
        check("rst_leds", 32'(leds), 32'h1);
        check("rst_start", 32'(bus.fpu_start), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        reset = 1'b0;
        step();
        check("idle_ready0", 32'(bus.req0_ready), 32'd0);
        check("idle_ready1", 32'(bus.req1_ready), 32'd0);

        // Single op: 1.0 + 2.0 = 3.0, unit done after 3 cycles
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F80_0000; bus.req0_b = 32'h4000_0000; bus.req0_op = 1'b0;
        #1;
        check("single_ready0", 32'(bus.req0_ready), 32'd1);
        check("single_ready1", 32'(bus.req1_ready), 32'd0);
        step();
        bus.req0_valid = 1'b0;
        check("single_start", 32'(bus.fpu_start), 32'd1);
        check("single_leds_issue", 32'(leds), 32'h2);
        check("single_fpu_a", bus.fpu_a, 32'h3F80_0000);
        check("single_fpu_b", bus.fpu_b, 32'h4000_0000);
        check("single_op", 32'(bus.fpu_opSel), 32'd0);
        check("issue_ready0", 32'(bus.req0_ready), 32'd0);
        serve(3, 32'h4040_0000);
        check("single_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("single_rsp_id", 32'(bus.rsp_id), 32'd0);
        check("single_rsp_data", bus.rsp_data, 32'h4040_0000);
        check("single_rsp_err", 32'(bus.rsp_err), 32'd0);
        check("single_leds_resp", 32'(leds), 32'h8);
        step();
        check("single_back_idle", 32'(leds), 32'h1);
        check("single_rsp_drop", 32'(bus.rsp_valid), 32'd0);

        // Spurious done in ISSUE is ignored, the real one is returned
        bus.req0_valid = 1'b1; bus.req0_a = 32'h4080_0000; bus.req0_b = 32'h3F80_0000; bus.req0_op = 1'b1;
        step();
        bus.req0_valid = 1'b0;
        check("spur_start", 32'(bus.fpu_start), 32'd1);
        check("spur_op", 32'(bus.fpu_opSel), 32'd1);
        bus.fpu_done = 1'b1; bus.fpu_result = 32'hDEAD_BEEF;
        step();
        bus.fpu_done = 1'b0; bus.fpu_result = '0;
        check("spur_still_wait", 32'(leds), 32'h4);
        check("spur_no_rsp", 32'(bus.rsp_valid), 32'd0);
        step();
        bus.fpu_done = 1'b1; bus.fpu_result = 32'h4040_0000;
        step();
        bus.fpu_done = 1'b0; bus.fpu_result = '0;
        check("spur_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("spur_rsp_data", bus.rsp_data, 32'h4040_0000);
        step();

        // Backpressure: response held while rsp_ready=0, req1 kept waiting
        bus.rsp_ready  = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h4000_0000; bus.req0_op = 1'b0;
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 32'h4120_0000; bus.req1_b = 32'h3F80_0000; bus.req1_op = 1'b1;
        serve(1, 32'h4080_0000);
        for (int i = 0; i < 5; i++) begin
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_data", bus.rsp_data, 32'h4080_0000);
            check("bp_rsp_id", 32'(bus.rsp_id), 32'd0);
            check("bp_req1_ready", 32'(bus.req1_ready), 32'd0);
            step();
        end
        check("bp_still_resp", 32'(leds), 32'h8);
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_req1_ready_resp", 32'(bus.req1_ready), 32'd0);
        step();
        check("bp_idle_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("bp_req1_ready_idle", 32'(bus.req1_ready), 32'd1);
        step();
        bus.req1_valid = 1'b0;
        check("bp_req1_start", 32'(bus.fpu_start), 32'd1);
        check("bp_req1_fpu_a", bus.fpu_a, 32'h4120_0000);
        serve(2, 32'h4110_0000);
        check("bp_req1_rsp_id", 32'(bus.rsp_id), 32'd1);
        check("bp_req1_rsp_data", bus.rsp_data, 32'h4110_0000);
        step();

        // Timeout: unit never answers; 16 cycles in WAIT, then qNaN with error
        bus.req1_valid = 1'b1; bus.req1_a = 32'h3F80_0000; bus.req1_b = 32'h3F80_0000; bus.req1_op = 1'b0;
        wait_for_start("to_start");
        bus.req1_valid = 1'b0;
        wc = 0;
        step();
        while (leds == 4'b0100 && wc < 40) begin
            check("to_no_rsp_in_wait", 32'(bus.rsp_valid), 32'd0);
            wc++;
            step();
        end
        check("to_wait_cycles", 32'(wc), 32'(TIMEOUT));
        check("to_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("to_rsp_data", bus.rsp_data, 32'h7FC0_0000);
        check("to_rsp_err", 32'(bus.rsp_err), 32'd1);
        check("to_rsp_id", 32'(bus.rsp_id), 32'd1);
        step();

        // Reset in the middle of WAIT drops the operation immediately
        bus.req0_valid = 1'b1; bus.req0_a = 32'h4000_0000; bus.req0_b = 32'h3F80_0000; bus.req0_op = 1'b0;
        wait_for_start("mid_start");
        bus.req0_valid = 1'b0;
        step(); step();
        check("mid_in_wait", 32'(leds), 32'h4);
        reset = 1'b1;
        #1;
        check("mid_rst_leds", 32'(leds), 32'h1);
        check("mid_rst_start", 32'(bus.fpu_start), 32'd0);
        check("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        step();
        reset = 1'b0;
        step(); step();
        check("mid_rst_stay_idle", 32'(leds), 32'h1);

        // Contention: both held valid, grants alternate 0,1,0,1
        op_a[0] = 32'h4000_0000; op_b[0] = 32'h3F80_0000;
        op_a[1] = 32'h4100_0000; op_b[1] = 32'h4080_0000;
        bus.req0_valid = 1'b1; bus.req0_a = op_a[0]; bus.req0_b = op_b[0]; bus.req0_op = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = op_a[1]; bus.req1_b = op_b[1]; bus.req1_op = 1'b1;
        #1;
        check("cont_ready0_first", 32'(bus.req0_ready), 32'd1);
        check("cont_ready1_first", 32'(bus.req1_ready), 32'd0);
        exp_id = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_for_start("cont_start");
            check("cont_fpu_a", bus.fpu_a, op_a[exp_id]);
            check("cont_fpu_b", bus.fpu_b, op_b[exp_id]);
            check("cont_op", 32'(bus.fpu_opSel), 32'(exp_id));
            serve(1, 32'h1000_0000 + 32'(k));
            check("cont_rsp_id", 32'(bus.rsp_id), 32'(exp_id));
            check("cont_rsp_data", bus.rsp_data, 32'h1000_0000 + 32'(k));
            if (k == 3) begin
                bus.req0_valid = 1'b0;
                bus.req1_valid = 1'b0;
            end
            exp_id = ~exp_id;
        end
        step(); step();
        check("cont_end_idle", 32'(leds), 32'h1);
        check("cont_end_start", 32'(bus.fpu_start), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
